// File: rtl/serializer_4to1_pkg.sv
// serializer_4to1_pkg: shared constants and state encoding for the 4:1
// parallel-to-serial stage.
//   LANES   - number of lanes in a parallel word
//   SEL_W   - width of the mux select
//   state_e - FSM state encoding (IDLE / SHIFT / GAP)
package serializer_4to1_pkg;

  localparam int LANES = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/serializer_4to1_if.sv
// serializer_4to1_if: parallel-in / serial-out handshake bundle.
//   in_data/in_valid/in_ready      - parallel word handshake (producer side)
//   out_bit/out_valid/out_ready    - serial bit handshake (consumer side)
//   out_last                       - current bit is the final lane of the word
//   sel, busy                      - debug visibility of the select and FSM
// Modports: slave = the serializer, master = the surrounding producer/consumer.
interface serializer_4to1_if;
  import serializer_4to1_pkg::*;

  logic [LANES-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             out_bit;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [SEL_W-1:0] sel;
  logic             busy;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_bit, out_valid, out_last, sel, busy
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_bit, out_valid, out_last, sel, busy
  );

endinterface

// File: rtl/mux_4to1.sv
// mux_4to1: 4-input, 1-bit combinational multiplexer.
//   i - four data inputs, input k selected when s == k
//   s - 2-bit select
//   y - selected bit
module mux_4to1 (
  input  logic [3:0] i,
  input  logic [1:0] s,
  output logic       y
);

  assign y = i[s];

endmodule

// File: rtl/serializer_4to1.sv
// serializer_4to1: accepts a 4-bit word on a valid/ready handshake, holds it,
// and walks the mux select across all four lanes to emit one bit per output
// beat, flagging the final lane with out_last.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - serializer_4to1_if.slave (parallel in, serial out, debug)
// Parameters:
//   MSB_FIRST  - 0: lane 0 first (sel 0->3); 1: lane 3 first (sel 3->0)
//   GAP_CYCLES - idle cycles after each word's last bit (0..3)
module serializer_4to1
  import serializer_4to1_pkg::*;
#(
  parameter bit MSB_FIRST  = 1'b0,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  serializer_4to1_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SHIFT = SHIFT;
  localparam logic [1:0] S_GAP   = GAP;

  localparam logic [SEL_W-1:0] START_LANE = MSB_FIRST ? SEL_W'(LANES-1) : '0;
  localparam logic [SEL_W-1:0] END_LANE   = MSB_FIRST ? '0 : SEL_W'(LANES-1);
  localparam logic [SEL_W-1:0] SEL_STEP   = MSB_FIRST ? '1 : SEL_W'(1);  // -1 or +1 mod 4
  localparam logic [1:0]       GAP_LOAD   = 2'(GAP_CYCLES - 1);

  logic [1:0]       state;
  logic [LANES-1:0] hold;
  logic [SEL_W-1:0] sel;
  logic [1:0]       gap_cnt;

  logic shifting, beat, last_lane, word_done, in_xfer;

  assign shifting  = (state == S_SHIFT);
  assign beat      = shifting && bus.out_ready;
  assign last_lane = (sel == END_LANE);
  assign word_done = beat && last_lane;

  // With no gap, the last-beat cycle doubles as the load slot for the next
  // word, so back-to-back words stream with no bubble.
  assign bus.in_ready  = (state == S_IDLE) || ((GAP_CYCLES == 0) && word_done);
  assign in_xfer       = bus.in_valid && bus.in_ready;

  assign bus.out_valid = shifting;
  assign bus.out_last  = shifting && last_lane;
  assign bus.busy      = (state != S_IDLE);
  assign bus.sel       = sel;

  mux_4to1 u_mux (
    .i (hold),
    .s (sel),
    .y (bus.out_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      hold    <= '0;
      sel     <= START_LANE;
      gap_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_xfer) begin
            hold  <= bus.in_data;
            sel   <= START_LANE;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (beat) begin
            // Stepping past the end lane wraps straight back to START_LANE,
            // so sel is already primed for the next word.
            sel <= sel + SEL_STEP;
            if (last_lane) begin
              if (GAP_CYCLES == 0) begin
                if (in_xfer) hold  <= bus.in_data;
                else         state <= S_IDLE;
              end else begin
                gap_cnt <= GAP_LOAD;
                state   <= S_GAP;
              end
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == 2'd0) state   <= S_IDLE;
          else                 gap_cnt <= gap_cnt - 2'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serializer_4to1.sv
module tb_serializer_4to1;
  import serializer_4to1_pkg::*;

  typedef struct packed {
    logic       b;
    logic [1:0] s;
    logic       last;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   passes = 0;
  exp_t exp_q[$];

  serializer_4to1_if if_lsb ();
  serializer_4to1_if if_msb ();
  serializer_4to1_if if_gap ();

  serializer_4to1 #(.MSB_FIRST(1'b0), .GAP_CYCLES(0)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(if_lsb));
  serializer_4to1 #(.MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_msb (.clk(clk), .rst_n(rst_n), .bus(if_msb));
  serializer_4to1 #(.MSB_FIRST(1'b0), .GAP_CYCLES(2)) u_gap (.clk(clk), .rst_n(rst_n), .bus(if_gap));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected serial stream of one word: lane order depends on direction.
  function automatic void push_word(input logic [3:0] w, input bit msb);
    for (int k = 0; k < 4; k++) begin
      int lane;
      exp_t e;
      lane   = msb ? 3 - k : k;
      e.b    = w[lane];
      e.s    = 2'(lane);
      e.last = (k == 3);
      exp_q.push_back(e);
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    if_lsb.in_valid = 0; if_lsb.in_data = '0; if_lsb.out_ready = 1;
    if_msb.in_valid = 0; if_msb.in_data = '0; if_msb.out_ready = 1;
    if_gap.in_valid = 0; if_gap.in_data = '0; if_gap.out_ready = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (if_lsb.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", if_lsb.out_valid); else passes++;
    checks++; if (if_lsb.busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", if_lsb.busy); else passes++;
    checks++; if (if_lsb.out_last !== 1'b0) $display("FAIL rst_out_last got %b exp 0", if_lsb.out_last); else passes++;
    checks++; if (if_lsb.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", if_lsb.in_ready); else passes++;
    checks++; if (if_lsb.sel !== 2'd0) $display("FAIL rst_sel_lsb got %0d exp 0", if_lsb.sel); else passes++;
    checks++; if (if_msb.sel !== 2'd3) $display("FAIL rst_sel_msb got %0d exp 3", if_msb.sel); else passes++;
    checks++; if (if_gap.in_ready !== 1'b1) $display("FAIL rst_in_ready_gap got %b exp 1", if_gap.in_ready); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lsb_basic();
    exp_t e;
    int   beats = 0;
    @(negedge clk);
    if_lsb.in_data = 4'b1011; if_lsb.in_valid = 1; if_lsb.out_ready = 1;
    #1;
    checks++; if (if_lsb.in_ready !== 1'b1) $display("FAIL lsb_accept in_ready got %b exp 1", if_lsb.in_ready); else passes++;
    push_word(4'b1011, 1'b0);
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if_lsb.in_valid = 0; if_lsb.in_data = 4'b0100;  // must be ignored
      #1;
      checks++; if (if_lsb.out_valid !== 1'b1) $display("FAIL lsb_contig out_valid got %b exp 1 cyc %0d", if_lsb.out_valid, c); else passes++;
      if (if_lsb.out_valid && if_lsb.out_ready) begin
        e = exp_q.pop_front();
        beats++;
        checks++; if (if_lsb.out_bit !== e.b) $display("FAIL lsb_bit got %b exp %b beat %0d", if_lsb.out_bit, e.b, beats); else passes++;
        checks++; if (if_lsb.sel !== e.s) $display("FAIL lsb_sel got %0d exp %0d", if_lsb.sel, e.s); else passes++;
        checks++; if (if_lsb.out_last !== e.last) $display("FAIL lsb_last got %b exp %b", if_lsb.out_last, e.last); else passes++;
        checks++; if (if_lsb.in_ready !== e.last) $display("FAIL lsb_in_ready_beat got %b exp %b", if_lsb.in_ready, e.last); else passes++;
      end
    end
    checks++; if (beats !== 4) $display("FAIL lsb_beats got %0d exp 4", beats); else passes++;
    exp_q.delete();
    @(negedge clk); #1;
    checks++; if (if_lsb.busy !== 1'b0 || if_lsb.in_ready !== 1'b1 || if_lsb.out_valid !== 1'b0)
      $display("FAIL lsb_idle busy %b in_ready %b out_valid %b exp 0 1 0", if_lsb.busy, if_lsb.in_ready, if_lsb.out_valid); else passes++;
  endtask

  task automatic test_msb_first();
    exp_t e;
    int   beats = 0;
    @(negedge clk);
    if_msb.in_data = 4'b1000; if_msb.in_valid = 1; if_msb.out_ready = 1;
    #1;
    if (if_msb.in_ready) push_word(4'b1000, 1'b1);
    checks++; if (if_msb.in_ready !== 1'b1) $display("FAIL msb_accept in_ready got %b exp 1", if_msb.in_ready); else passes++;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if_msb.in_valid = 0;
      #1;
      if (if_msb.out_valid && if_msb.out_ready) begin
        e = exp_q.pop_front();
        beats++;
        checks++; if (if_msb.out_bit !== e.b) $display("FAIL msb_bit got %b exp %b beat %0d", if_msb.out_bit, e.b, beats); else passes++;
        checks++; if (if_msb.sel !== e.s) $display("FAIL msb_sel got %0d exp %0d", if_msb.sel, e.s); else passes++;
        checks++; if (if_msb.out_last !== e.last) $display("FAIL msb_last got %b exp %b", if_msb.out_last, e.last); else passes++;
      end
    end
    checks++; if (beats !== 4) $display("FAIL msb_beats got %0d exp 4", beats); else passes++;
    exp_q.delete();
    @(negedge clk); #1;
    checks++; if (if_msb.busy !== 1'b0 || if_msb.sel !== 2'd3) $display("FAIL msb_idle busy %b sel %0d exp 0 3", if_msb.busy, if_msb.sel); else passes++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   beats = 0, rdy_pulses = 0, sent;
    @(negedge clk);
    if_lsb.in_data = 4'hA; if_lsb.in_valid = 1; if_lsb.out_ready = 1;
    #1;
    checks++; if (if_lsb.in_ready !== 1'b1) $display("FAIL b2b_accept in_ready got %b exp 1", if_lsb.in_ready); else passes++;
    push_word(4'hA, 1'b0);
    sent = 1;
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (sent < 2) begin if_lsb.in_valid = 1; if_lsb.in_data = 4'h5; end
      else if_lsb.in_valid = 0;
      #1;
      checks++; if (if_lsb.out_valid !== 1'b1) $display("FAIL b2b_contig out_valid got %b exp 1 cyc %0d", if_lsb.out_valid, c); else passes++;
      if (if_lsb.in_ready) rdy_pulses++;
      if (if_lsb.out_valid && if_lsb.out_ready) begin
        e = exp_q.pop_front();
        beats++;
        checks++; if (if_lsb.out_bit !== e.b) $display("FAIL b2b_bit got %b exp %b beat %0d", if_lsb.out_bit, e.b, beats); else passes++;
        checks++; if (if_lsb.in_ready !== e.last) $display("FAIL b2b_in_ready got %b exp %b beat %0d", if_lsb.in_ready, e.last, beats); else passes++;
      end
      if (if_lsb.in_valid && if_lsb.in_ready) begin
        push_word(4'h5, 1'b0);
        sent++;
      end
    end
    if_lsb.in_valid = 0;
    checks++; if (beats !== 8) $display("FAIL b2b_beats got %0d exp 8", beats); else passes++;
    checks++; if (rdy_pulses !== 2) $display("FAIL b2b_ready_pulses got %0d exp 2", rdy_pulses); else passes++;
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   beats = 0;
    @(negedge clk);
    if_lsb.in_data = 4'b0110; if_lsb.in_valid = 1; if_lsb.out_ready = 1;
    #1;
    if (if_lsb.in_ready) push_word(4'b0110, 1'b0);
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if_lsb.in_valid = 0;
      if_lsb.out_ready = !(c >= 1 && c <= 3);
      #1;
      checks++; if (if_lsb.out_valid !== 1'b1) $display("FAIL bp_out_valid got %b exp 1 cyc %0d", if_lsb.out_valid, c); else passes++;
      if (!if_lsb.out_ready) begin
        checks++; if (if_lsb.sel !== 2'd1 || if_lsb.out_bit !== 1'b1)
          $display("FAIL bp_stall sel %0d bit %b exp 1 1", if_lsb.sel, if_lsb.out_bit); else passes++;
      end
      if (if_lsb.out_valid && if_lsb.out_ready) begin
        e = exp_q.pop_front();
        beats++;
        checks++; if (if_lsb.out_bit !== e.b || if_lsb.sel !== e.s)
          $display("FAIL bp_beat bit %b sel %0d exp %b %0d", if_lsb.out_bit, if_lsb.sel, e.b, e.s); else passes++;
      end
    end
    if_lsb.out_ready = 1;
    checks++; if (beats !== 4) $display("FAIL bp_beats got %0d exp 4", beats); else passes++;
    exp_q.delete();
  endtask

  task automatic test_gap();
    exp_t       e;
    logic [3:0] words [2];
    int sent = 0, pops = 0, gap_obs = 0, reload_cyc = -100, idx;
    bit in_window = 0;
    words[0] = 4'h3; words[1] = 4'hC;
    if_gap.out_ready = 1;
    for (int c = 0; c < 60; c++) begin
      if (sent == 2 && exp_q.size() == 0) break;
      @(negedge clk);
      idx = (sent < 2) ? sent : 1;
      if_gap.in_valid = (sent < 2);
      if_gap.in_data  = words[idx];
      #1;
      if (in_window && !if_gap.out_valid && !if_gap.in_ready) gap_obs++;
      if (if_gap.out_valid && if_gap.out_ready) begin
        e = exp_q.pop_front();
        checks++; if (if_gap.out_bit !== e.b || if_gap.sel !== e.s || if_gap.out_last !== e.last)
          $display("FAIL gap_beat bit %b sel %0d last %b exp %b %0d %b", if_gap.out_bit, if_gap.sel, if_gap.out_last, e.b, e.s, e.last); else passes++;
        checks++; if (if_gap.in_ready !== 1'b0) $display("FAIL gap_in_ready_shift got %b exp 0", if_gap.in_ready); else passes++;
        if (pops == 4) begin
          checks++; if (c !== reload_cyc + 1) $display("FAIL gap_first_bit_latency got cyc %0d exp %0d", c, reload_cyc + 1); else passes++;
        end
        if (e.last && sent == 1) in_window = 1;
        pops++;
      end
      if (if_gap.in_valid && if_gap.in_ready) begin
        push_word(words[idx], 1'b0);
        if (sent == 1) begin reload_cyc = c; in_window = 0; end
        sent++;
      end
    end
    if_gap.in_valid = 0;
    checks++; if (pops !== 8) $display("FAIL gap_beats got %0d exp 8", pops); else passes++;
    checks++; if (gap_obs !== 2) $display("FAIL gap_idle_cycles got %0d exp 2", gap_obs); else passes++;
    exp_q.delete();
    repeat (4) @(negedge clk);
    #1;
    checks++; if (if_gap.busy !== 1'b0) $display("FAIL gap_return_idle busy got %b exp 0", if_gap.busy); else passes++;
  endtask

  task automatic test_async_reset();
    exp_t e;
    bit   hit = 0;
    int   beats = 0;
    @(negedge clk);
    if_lsb.in_data = 4'b1111; if_lsb.in_valid = 1; if_lsb.out_ready = 1;
    for (int c = 0; c < 10 && !hit; c++) begin
      @(negedge clk);
      if_lsb.in_valid = 0;
      #1;
      if (if_lsb.out_valid && if_lsb.sel == 2'd2) hit = 1;
    end
    checks++; if (!hit) $display("FAIL ar_reach_sel2 got 0 exp 1"); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (if_lsb.out_valid !== 1'b0 || if_lsb.busy !== 1'b0 || if_lsb.out_last !== 1'b0)
      $display("FAIL ar_immediate out_valid %b busy %b last %b exp 0 0 0", if_lsb.out_valid, if_lsb.busy, if_lsb.out_last); else passes++;
    checks++; if (if_lsb.sel !== 2'd0) $display("FAIL ar_sel got %0d exp 0", if_lsb.sel); else passes++;
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++; if (if_lsb.out_valid !== 1'b0) $display("FAIL ar_residual out_valid got %b exp 0 cyc %0d", if_lsb.out_valid, c); else passes++;
    end
    exp_q.delete();
    @(negedge clk);
    if_lsb.in_data = 4'b0001; if_lsb.in_valid = 1;
    #1;
    if (if_lsb.in_ready) push_word(4'b0001, 1'b0);
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if_lsb.in_valid = 0;
      #1;
      if (if_lsb.out_valid && if_lsb.out_ready) begin
        e = exp_q.pop_front();
        beats++;
        checks++; if (if_lsb.out_bit !== e.b || if_lsb.sel !== e.s)
          $display("FAIL ar_next_word bit %b sel %0d exp %b %0d", if_lsb.out_bit, if_lsb.sel, e.b, e.s); else passes++;
      end
    end
    checks++; if (beats !== 4) $display("FAIL ar_next_beats got %0d exp 4", beats); else passes++;
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_lsb_basic();
    test_msb_first();
    test_back_to_back();
    test_backpressure();
    test_gap();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
